eq_gain_scheduler: RTL and testbench

Control-plane scheduler for the three-band equalizer and the LM4811 headphone amplifier. It debounces the eight raw user buttons and turns each press into one pending up/down request. Band-gain updates are granted round-robin through a single shared saturating step unit, one grant per audio frame at `frame_sync`. Volume requests are sequenced onto the LM4811 `clk`/`ud` serial pins. It sits beside the equalizer datapath and drives its `lgain`/`mgain`/`hgain` inputs.

---
 rtl/eq_gain_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_eq_gain_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_gain_scheduler.sv
// Purpose : debounce 8 user buttons into per-band/volume up/down requests, grant one band
//           gain step per frame_sync (round-robin L->M->H), sequence volume steps onto LM4811.
// Latency : press commits 1+DEB_CYCLES edges after first high sample; gain visible after the
//           granting frame_sync edge; LM4811 clk low LM_DLY cycles then high LM_DLY cycles.
// Backpressure: none; a press on an already-pending bit, or an up+down pair on one requester,
//           is discarded and flagged on o_req_drop.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_btn[7:0]                raw buttons {vol_dn, vol_up, hdn, hup, mdn, mup, ldn, lup}
//   i_frame_sync              one-cycle pulse per audio frame (gain commit point)
//   o_lgain/o_mgain/o_hgain   band gains, unsigned
//   o_lm4811_clk/o_lm4811_ud  LM4811 step clock (idles high) and direction (1 = up)
//   o_vol_busy                volume sequencer active
//   o_req_drop                one-cycle pulse when a press was discarded
`timescale 1ns/1ps
module eq_gain_scheduler #(
  parameter int            DW         = 32,
  parameter logic [DW-1:0] GAIN_INIT  = 32'h0000_4000,
  parameter logic [DW-1:0] GAIN_STEP  = 32'h0000_0800,
  parameter logic [DW-1:0] GAIN_MAX   = 32'h0000_F800,
  parameter int            DEB_CYCLES = 16,
  parameter int            LM_DLY     = 5096
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_btn,
  input  logic          i_frame_sync,
  output logic [DW-1:0] o_lgain,
  output logic [DW-1:0] o_mgain,
  output logic [DW-1:0] o_hgain,
  output logic          o_lm4811_clk,
  output logic          o_lm4811_ud,
  output logic          o_vol_busy,
  output logic          o_req_drop
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam int            LW       = $clog2(LM_DLY);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LM_LAST  = LW'(LM_DLY - 1);

  // ---------------- input stage: sync + debounce ----------------
  logic [7:0]    r_sync1, r_sync2, r_deb;
  logic [CW-1:0] r_deb_cnt [8];
  logic [7:0]    w_commit, w_press;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_commit[i] = (r_sync2[i] != r_deb[i]) && (r_deb_cnt[i] == DEB_LAST);
    end
  end
  // A commit toward 1 is a press; pending bits are set on the same edge as the commit.
  assign w_press = w_commit & r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 8; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 8; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (w_commit[i]) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---------------- requesters: 0=L 1=M 2=H 3=VOL ----------------
  logic [3:0] r_pend_up, r_pend_dn;
  logic [3:0] w_press_up, w_press_dn, w_conflict, w_elig, w_clr;
  logic       r_req_drop;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_press_up[r] = w_press[2*r];
      w_press_dn[r] = w_press[2*r+1];
    end
  end
  assign w_conflict = r_pend_up & r_pend_dn;
  // Only a single-direction request is serviceable; a conflicting pair is cancelled instead.
  assign w_elig     = r_pend_up ^ r_pend_dn;

  // ---------------- gain arbiter + shared step unit ----------------
  logic [1:0]    r_rr, w_gnt_idx;
  logic          w_gnt_vld, w_gnt, w_dir_up;
  logic [2:0]    w_scan;
  logic [DW-1:0] r_lgain, r_mgain, r_hgain, w_gain_sel, w_gain_nxt;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_rr;
    w_scan    = '0;
    for (int k = 0; k < 3; k++) begin
      w_scan = {1'b0, r_rr} + 3'(k);
      if (w_scan >= 3'd3) w_scan = w_scan - 3'd3;
      if (!w_gnt_vld && w_elig[w_scan[1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan[1:0];
      end
    end
  end
  assign w_gnt    = i_frame_sync & w_gnt_vld;
  assign w_dir_up = r_pend_up[w_gnt_idx];

  always_comb begin
    case (w_gnt_idx)
      2'd1:    w_gain_sel = r_mgain;
      2'd2:    w_gain_sel = r_hgain;
      default: w_gain_sel = r_lgain;
    endcase
    // Compare before adding/subtracting so the result can never wrap.
    if (w_dir_up)
      w_gain_nxt = (w_gain_sel >= GAIN_MAX - GAIN_STEP) ? GAIN_MAX : w_gain_sel + GAIN_STEP;
    else
      w_gain_nxt = (w_gain_sel < GAIN_STEP) ? '0 : w_gain_sel - GAIN_STEP;
  end

  // ---------------- LM4811 volume sequencer ----------------
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH} vol_st_t;
  vol_st_t       r_vst, w_vst_nxt;
  logic [LW-1:0] r_lm_cnt, w_lm_cnt_nxt;
  logic          r_lm_clk, w_lm_clk_nxt, r_lm_ud, w_lm_ud_nxt, w_vol_acc;

  always_comb begin
    w_vst_nxt    = r_vst;
    w_lm_cnt_nxt = r_lm_cnt;
    w_lm_clk_nxt = r_lm_clk;
    w_lm_ud_nxt  = r_lm_ud;
    w_vol_acc    = 1'b0;
    case (r_vst)
      ST_IDLE: begin
        if (w_elig[3]) begin
          w_vol_acc    = 1'b1;
          w_lm_ud_nxt  = r_pend_up[3];
          w_lm_clk_nxt = 1'b0;
          w_lm_cnt_nxt = '0;
          w_vst_nxt    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_lm_cnt == LM_LAST) begin
          w_lm_clk_nxt = 1'b1;
          w_lm_cnt_nxt = '0;
          w_vst_nxt    = ST_HIGH;
        end else begin
          w_lm_cnt_nxt = r_lm_cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (r_lm_cnt == LM_LAST) begin
          w_lm_cnt_nxt = '0;
          w_vst_nxt    = ST_IDLE;
        end else begin
          w_lm_cnt_nxt = r_lm_cnt + 1'b1;
        end
      end
      default: w_vst_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clr    = '0;
    w_clr[3] = w_vol_acc;
    if (w_gnt) w_clr[w_gnt_idx] = 1'b1;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_up  <= '0;
      r_pend_dn  <= '0;
      r_req_drop <= 1'b0;
      r_rr       <= 2'd0;
      r_lgain    <= GAIN_INIT;
      r_mgain    <= GAIN_INIT;
      r_hgain    <= GAIN_INIT;
      r_vst      <= ST_IDLE;
      r_lm_cnt   <= '0;
      r_lm_clk   <= 1'b1;
      r_lm_ud    <= 1'b0;
    end else begin
      // A press on a bit that is set (even if being granted now) is dropped, not re-queued.
      r_pend_up  <= ~w_conflict & ((r_pend_up & ~w_clr) | (w_press_up & ~r_pend_up));
      r_pend_dn  <= ~w_conflict & ((r_pend_dn & ~w_clr) | (w_press_dn & ~r_pend_dn));
      r_req_drop <= (|(w_press_up & r_pend_up)) | (|(w_press_dn & r_pend_dn)) | (|w_conflict);
      if (w_gnt) begin
        r_rr <= (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;
        case (w_gnt_idx)
          2'd1:    r_mgain <= w_gain_nxt;
          2'd2:    r_hgain <= w_gain_nxt;
          default: r_lgain <= w_gain_nxt;
        endcase
      end
      r_vst    <= w_vst_nxt;
      r_lm_cnt <= w_lm_cnt_nxt;
      r_lm_clk <= w_lm_clk_nxt;
      r_lm_ud  <= w_lm_ud_nxt;
    end
  end

  assign o_lgain      = r_lgain;
  assign o_mgain      = r_mgain;
  assign o_hgain      = r_hgain;
  assign o_lm4811_clk = r_lm_clk;
  assign o_lm4811_ud  = r_lm_ud;
  assign o_vol_busy   = (r_vst != ST_IDLE);
  assign o_req_drop   = r_req_drop;

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Purpose : self-checking bench for eq_gain_scheduler (DEB_CYCLES=4, LM_DLY=8).
// Latency : expected gain updates queued at stimulus time, popped when a gain output changes.
// Backpressure: n/a; every wait on the DUT is bounded.
`timescale 1ns/1ps
module tb_eq_gain_scheduler;
  localparam logic [31:0] INIT = 32'h0000_4000;
  localparam logic [31:0] STEP = 32'h0000_0800;
  localparam logic [31:0] GMAX = 32'h0000_F800;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  btn   = 8'h00;
  logic        fs    = 1'b0;
  logic [31:0] lgain, mgain, hgain;
  logic        lm_clk, lm_ud, vol_busy, req_drop;

  always #5 clk = ~clk;

  eq_gain_scheduler #(
    .DW(32), .GAIN_INIT(INIT), .GAIN_STEP(STEP), .GAIN_MAX(GMAX),
    .DEB_CYCLES(4), .LM_DLY(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .i_frame_sync(fs),
    .o_lgain(lgain), .o_mgain(mgain), .o_hgain(hgain),
    .o_lm4811_clk(lm_clk), .o_lm4811_ud(lm_ud),
    .o_vol_busy(vol_busy), .o_req_drop(req_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int drop_seen = 0;

  typedef struct {
    int          band;
    logic [31:0] val;
  } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model   [3];
  logic [31:0] prev    [3];
  logic [31:0] mon_cur [3];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference step: saturating add/sub written independently of the DUT formulation.
  function automatic logic [31:0] step_ref(input logic [31:0] g, input bit up);
    if (up) return (g + STEP > GMAX) ? GMAX : g + STEP;
    else    return (g > STEP) ? g - STEP : 32'h0;
  endfunction

  // Queue the gain change a grant should produce (a saturated no-op is invisible).
  task automatic expect_grant(input int band, input bit up);
    logic [31:0] nv;
    nv = step_ref(model[band], up);
    if (nv != model[band]) begin
      sb.push_back('{band, nv});
      model[band] = nv;
    end
  endtask

  // Scoreboard monitor: any gain movement must match the head of the queue.
  always @(negedge clk) begin
    mon_cur[0] = lgain;
    mon_cur[1] = mgain;
    mon_cur[2] = hgain;
    if (!rst_n) begin
      for (int b = 0; b < 3; b++) prev[b] = mon_cur[b];
    end else begin
      if (req_drop) drop_seen++;
      for (int b = 0; b < 3; b++) begin
        if (mon_cur[b] !== prev[b]) begin
          if (sb.size() == 0) begin
            chk_eq("sb_unexpected", mon_cur[b], prev[b]);
          end else begin
            mon_e = sb.pop_front();
            chk_eq("sb_band", b, mon_e.band);
            chk_eq("sb_gain", mon_cur[b], mon_e.val);
          end
          prev[b] = mon_cur[b];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] m);
    btn = btn | m;
    repeat (7) tick();
    btn = btn & ~m;
    repeat (7) tick();
  endtask

  task automatic frame();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) model[b] = INIT;
  endtask

  // Measure one LM4811 pulse: low phase length, busy length, direction stability.
  task automatic vol_measure(input logic exp_ud, input string tag);
    int   n, lo, bz;
    logic ud_obs;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (lm_clk !== 1'b0 && n < 200);
    if (lm_clk !== 1'b0) begin
      chk_eq({tag, "_timeout"}, lm_clk, 1'b0);
      return;
    end
    lo = 0;
    bz = 0;
    ud_obs = exp_ud;
    while (vol_busy === 1'b1 && bz < 100) begin
      bz++;
      if (lm_clk === 1'b0) begin
        lo++;
        if (lm_ud !== exp_ud) ud_obs = lm_ud;
      end
      @(negedge clk);
    end
    chk_eq({tag, "_low"},  lo, 8);
    chk_eq({tag, "_busy"}, bz, 16);
    chk_eq({tag, "_ud"},   ud_obs, exp_ud);
    chk_eq({tag, "_clkhi"}, lm_clk, 1'b1);
  endtask

  initial begin
    int d0, n;
    for (int b = 0; b < 3; b++) model[b] = INIT;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state, idle frames produce nothing.
    repeat (3) begin
      repeat (5) tick();
      frame();
    end
    chk_eq("rst_lgain", lgain, INIT);
    chk_eq("rst_mgain", mgain, INIT);
    chk_eq("rst_hgain", hgain, INIT);
    chk_eq("rst_lmclk", lm_clk, 1'b1);
    chk_eq("rst_lmud",  lm_ud, 1'b0);
    chk_eq("rst_busy",  vol_busy, 1'b0);
    chk_eq("rst_drop",  req_drop, 1'b0);

    // Single lup, commit timing relative to frame_sync.
    btn[0] = 1'b1;
    repeat (10) tick();
    btn[0] = 1'b0;
    repeat (7) tick();
    chk_eq("l_pre", lgain, INIT);
    expect_grant(0, 1'b1);
    frame();
    chk_eq("l_post", lgain, 32'h4800);
    chk_eq("l_m_same", mgain, INIT);
    chk_eq("l_h_same", hgain, INIT);

    // Short glitch on mup must be ignored.
    btn[2] = 1'b1;
    repeat (3) tick();
    btn[2] = 1'b0;
    repeat (8) tick();
    frame();
    repeat (2) tick();
    chk_eq("glitch_m", mgain, INIT);
    chk_eq("glitch_drop", drop_seen, 0);

    // Simultaneous L/M/H presses: one grant per frame, round-robin from L.
    do_reset();
    press(8'b0001_0101);
    expect_grant(0, 1'b1); frame(); chk_eq("rr_l", lgain, 32'h4800);
    expect_grant(1, 1'b1); frame(); chk_eq("rr_m", mgain, 32'h4800);
    expect_grant(2, 1'b1); frame(); chk_eq("rr_h", hgain, 32'h4800);
    // Pointer is back at L: with H and L pending, L wins first.
    press(8'b0001_0001);
    expect_grant(0, 1'b1); frame();
    chk_eq("rr2_l", lgain, 32'h5000);
    chk_eq("rr2_h_wait", hgain, 32'h4800);
    expect_grant(2, 1'b1); frame();
    chk_eq("rr2_h", hgain, 32'h5000);

    // Saturation at both ends on H.
    repeat (32) begin press(8'h10); expect_grant(2, 1'b1); frame(); end
    chk_eq("sat_hi", hgain, GMAX);
    repeat (16) begin press(8'h20); expect_grant(2, 1'b0); frame(); end
    chk_eq("sat_mid", hgain, 32'h7800);
    repeat (16) begin press(8'h20); expect_grant(2, 1'b0); frame(); end
    chk_eq("sat_lo", hgain, 32'h0);

    // Up+down committed together cancel each other.
    d0 = drop_seen;
    press(8'h03);
    frame();
    tick();
    chk_eq("conf_drop", drop_seen - d0, 1);
    chk_eq("conf_lgain", lgain, model[0]);
    // Duplicate press before a frame: one drop, one step.
    d0 = drop_seen;
    press(8'h01);
    press(8'h01);
    expect_grant(0, 1'b1);
    frame();
    tick();
    chk_eq("dup_drop", drop_seen - d0, 1);
    chk_eq("dup_lgain", lgain, model[0]);

    // Volume up, then volume down arriving while busy.
    d0 = drop_seen;
    fork
      begin
        press(8'h40);
        press(8'h80);
      end
      begin
        vol_measure(1'b1, "vup");
        vol_measure(1'b0, "vdn");
      end
    join
    chk_eq("vol_drop", drop_seen - d0, 0);
    repeat (30) tick();
    chk_eq("vol_idle", vol_busy, 1'b0);
    chk_eq("sb_empty", sb.size(), 0);

    // Reset during SETUP releases the LM4811 clock immediately.
    fork
      press(8'h40);
      begin
        n = 0;
        while (lm_clk !== 1'b0 && n < 100) begin
          tick();
          n++;
        end
        if (lm_clk !== 1'b0) chk_eq("mid_rst_timeout", lm_clk, 1'b0);
        repeat (3) tick();
        chk_eq("mid_rst_pre_busy", vol_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_clk",  lm_clk, 1'b1);
        chk_eq("mid_rst_busy", vol_busy, 1'b0);
        chk_eq("mid_rst_ud",   lm_ud, 1'b0);
        chk_eq("mid_rst_gain", lgain, INIT);
      end
    join
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk_eq("post_rst_clk",  lm_clk, 1'b1);
    chk_eq("post_rst_busy", vol_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
